// File: rtl/neuron_mac_seq_if.sv
// Handshake bundle for neuron_mac_seq: beat input side (activations, weights,
// bias) and result output side. The DUT takes the slave modport.
interface neuron_mac_seq_if #(
  parameter int IN_W  = 5,
  parameter int W_W   = 5,
  parameter int LANES = 4,
  parameter int OUT_W = 12
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*IN_W-1:0]  in_data;
  logic [LANES*W_W-1:0]   w_data;
  logic [OUT_W-1:0]       bias;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       result;
  logic                   busy;

  modport slave (
    input  in_valid, in_data, w_data, bias, out_ready,
    output in_ready, out_valid, result, busy
  );

  modport master (
    output in_valid, in_data, w_data, bias, out_ready,
    input  in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron MAC: BEATS beats of LANES products plus bias, saturated to OUT_W.
// Optional macro NEURON_MAC_RELU_EN clamps negative results to zero after saturation.
module neuron_mac_seq #(
  parameter int IN_W  = 5,
  parameter int W_W   = 5,
  parameter int LANES = 4,
  parameter int BEATS = 4,
  parameter int ACC_W = 16,
  parameter int OUT_W = 12
) (
  input logic             clk,
  input logic             rst,
  neuron_mac_seq_if.slave bus
);

  localparam int PROD_W = IN_W + W_W;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {ACCUM, DRAIN, ROUND, HOLD} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic                      busy_q, busy_d;
  logic signed [OUT_W-1:0]   result_q, result_d;

  logic signed [PROD_W-1:0]  prod_p1_q [LANES];
  logic signed [PROD_W-1:0]  prod_p1_d [LANES];
  logic                      first_p1_q, first_p1_d;
  logic signed [ACC_W-1:0]   bias_p1_q, bias_p1_d;
  logic                      vld_p1_q, vld_p1_d;
  logic signed [ACC_W-1:0]   acc_p2_q, acc_p2_d;
  logic signed [ACC_W-1:0]   lane_sum;
  logic                      accept;

  function automatic logic signed [OUT_W-1:0] finalize(input logic signed [ACC_W-1:0] v);
    logic signed [OUT_W-1:0] s;
    if (v > SAT_MAX)      s = SAT_MAX[OUT_W-1:0];
    else if (v < SAT_MIN) s = SAT_MIN[OUT_W-1:0];
    else                  s = v[OUT_W-1:0];
`ifdef NEURON_MAC_RELU_EN
    if (s[OUT_W-1]) s = '0;
`else
`endif
    return s;
  endfunction

  assign accept = bus.in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: state_d = ROUND;
      ROUND: begin
        result_d    = finalize(acc_p2_q);
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
    in_ready_d = (state_d == ACCUM);
    busy_d     = !((state_d == ACCUM) && (beat_cnt_d == '0));
  end

  // Stage p1: per-lane products, first-beat flag and extended bias
  always_comb begin
    vld_p1_d   = accept;
    first_p1_d = first_p1_q;
    bias_p1_d  = bias_p1_q;
    for (int i = 0; i < LANES; i++) prod_p1_d[i] = prod_p1_q[i];
    if (accept) begin
      first_p1_d = (beat_cnt_q == '0);
      bias_p1_d  = ACC_W'($signed(bus.bias));
      for (int i = 0; i < LANES; i++) begin
        prod_p1_d[i] = PROD_W'($signed(bus.in_data[i*IN_W +: IN_W]))
                     * PROD_W'($signed(bus.w_data[i*W_W +: W_W]));
      end
    end
  end

  // Stage p2: accumulate; the first beat of a neuron reloads from bias
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + ACC_W'(prod_p1_q[i]);
    acc_p2_d = acc_p2_q;
    if (vld_p1_q) acc_p2_d = (first_p1_q ? bias_p1_q : acc_p2_q) + lane_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      beat_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      vld_p1_q    <= 1'b0;
      acc_p2_q    <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
      vld_p1_q    <= vld_p1_d;
      acc_p2_q    <= acc_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    first_p1_q <= first_p1_d;
    bias_p1_q  <= bias_p1_d;
    for (int i = 0; i < LANES; i++) prod_p1_q[i] <= prod_p1_d[i];
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: default 4x4 instance plus a BEATS=1, LANES=8 instance.
module tb_neuron_mac_seq;
  localparam int IN_W = 5, W_W = 5, LANES = 4, BEATS = 4, ACC_W = 16, OUT_W = 12;
  localparam int LANES8 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_mac_seq_if #(.IN_W(IN_W), .W_W(W_W), .LANES(LANES), .OUT_W(OUT_W)) bus ();
  neuron_mac_seq_if #(.IN_W(IN_W), .W_W(W_W), .LANES(LANES8), .OUT_W(OUT_W)) bus8 ();

  neuron_mac_seq #(.IN_W(IN_W), .W_W(W_W), .LANES(LANES), .BEATS(BEATS),
                   .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  neuron_mac_seq #(.IN_W(IN_W), .W_W(W_W), .LANES(LANES8), .BEATS(1),
                   .ACC_W(ACC_W), .OUT_W(OUT_W)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  function automatic int sat_ref(input int v);
    int r;
    if (v > 2047)       r = 2047;
    else if (v < -2048) r = -2048;
    else                r = v;
`ifdef NEURON_MAC_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_lanes(input int a, input int w, input int b);
    for (int i = 0; i < LANES; i++) begin
      bus.in_data[i*IN_W +: IN_W] = IN_W'(a);
      bus.w_data[i*W_W +: W_W]    = W_W'(w);
    end
    bus.bias = OUT_W'(b);
  endtask

  task automatic beat(input int a, input int w, input int b);
    set_lanes(a, w, b);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Last beat lands on edge k; out_valid must be low after k+1 and high after k+2.
  task automatic latency_check(input string tag);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_lat_k1"}, int'(bus.out_valid), 0);
    @(negedge clk);
    chk({tag, "_lat_k2"}, int'(bus.out_valid), 1);
  endtask

  task automatic vec(input string tag, input int a, input int w, input int b);
    for (int i = 0; i < BEATS; i++) beat(a, w, b);
    exp_q.push_back(sat_ref(b + LANES * BEATS * a * w));
    latency_check(tag);
  endtask

  task automatic take(input string tag);
    int e;
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    chk({tag, "_valid"}, int'(bus.out_valid), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -99999;
    chk({tag, "_result"}, int'($signed(bus.result)), e);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_vld_drop"}, int'(bus.out_valid), 0);
    chk({tag, "_rdy_back"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.out_ready = 1'b0;
    bus.in_data = '0;     bus.w_data = '0;  bus.bias = '0;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
    bus8.in_data = '0;    bus8.w_data = '0; bus8.bias = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_result", int'($signed(bus.result)), 0);
    chk("rst_busy", int'(bus.busy), 0);

    // Basic all-ones neuron
    vec("t1", 1, 1, 0);
    take("t1");

    // Positive and negative saturation
    vec("t2a", -16, -16, 0);
    take("t2a");
    vec("t2b", -16, 15, 0);
    take("t2b");

    // Two bubble cycles between beats 1 and 2
    beat(3, -2, 100);
    beat(3, -2, 100);
    repeat (2) begin
      @(negedge clk);
      chk("t3_bubble_busy", int'(bus.busy), 1);
      chk("t3_bubble_nvld", int'(bus.out_valid), 0);
      @(posedge clk);
      #1;
    end
    beat(3, -2, 100);
    beat(3, -2, 100);
    exp_q.push_back(sat_ref(100 + LANES * BEATS * 3 * (-2)));
    latency_check("t3");
    take("t3");

    // Backpressure: result held while out_ready low; junk beats ignored
    vec("t4", 1, 2, -5);
    set_lanes(15, 15, 0);
    bus.in_valid = 1'b1;
    e = exp_q[0];
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_result", int'($signed(bus.result)), e);
      chk("t4_hold_valid", int'(bus.out_valid), 1);
      chk("t4_hold_inrdy", int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    take("t4");

    // Reset mid-evaluation discards partial sum
    beat(1, 1, 500);
    beat(1, 1, 500);
    @(negedge clk);
    chk("t5_busy_mid", int'(bus.busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy", int'(bus.busy), 0);
    chk("t5_rst_inrdy", int'(bus.in_ready), 1);
    chk("t5_rst_result", int'($signed(bus.result)), 0);
    vec("t5", 2, 2, -1);
    take("t5");

    // Single-beat, 8-lane instance
    for (int i = 0; i < LANES8; i++) begin
      bus8.in_data[i*IN_W +: IN_W] = IN_W'(7);
      bus8.w_data[i*W_W +: W_W]    = W_W'(7);
    end
    bus8.bias = '0;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    exp_q.push_back(sat_ref(LANES8 * 7 * 7));
    @(negedge clk);
    @(negedge clk);
    chk("t6_lat_k1", int'(bus8.out_valid), 0);
    @(negedge clk);
    chk("t6_lat_k2", int'(bus8.out_valid), 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -99999;
    chk("t6_result", int'($signed(bus8.result)), e);
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1 bus8.out_ready = 1'b0;
    @(negedge clk);
    chk("t6_vld_drop", int'(bus8.out_valid), 0);
    chk("t6_rdy_back", int'(bus8.in_ready), 1);

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
